// File: rtl/despread_acq_ctrl.sv
// Code-phase acquisition and lock controller for the despread correlator.
// Walks the local code phase one chip per hypothesis (slip pulses), integrates
// |corr| over DwellEpochs epochs per hypothesis, locks on a threshold hit and
// drops back to search after MaxMisses consecutive failed dwells in track.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_clk_en            chip-rate enable; all state advances only when high
//   i_start             level; begins a search from IDLE
//   i_abort             pulse; returns to IDLE from any state
//   i_epoch             marks the chip carrying the full-period correlation
//   i_corr_in           signed correlator output
//   i_threshold         unsigned detection threshold
//   o_slip              one-cycle pulse: code generator holds one chip
//   o_code_phase        current hypothesis index
//   o_locked            high in TRACK
//   o_search_fail       one-cycle pulse when every phase has failed
//   o_loss_of_lock      one-cycle pulse on TRACK -> SETTLE
//   o_peak_phase        phase of largest dwell in the current search
//   o_peak_mag          largest dwell accumulation in the current search
//   o_state             0 IDLE, 1 SETTLE, 2 DWELL, 3 TRACK
module despread_acq_ctrl #(
    parameter int unsigned CodeLength  = 16,
    parameter int unsigned PhaseBits   = 4,
    parameter int unsigned DwellEpochs = 8,
    parameter int unsigned AccBits     = 24,
    parameter int unsigned MaxMisses   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_en,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_epoch,
    input  logic signed [17:0]   i_corr_in,
    input  logic [AccBits-1:0]   i_threshold,
    output logic                 o_slip,
    output logic [PhaseBits-1:0] o_code_phase,
    output logic                 o_locked,
    output logic                 o_search_fail,
    output logic                 o_loss_of_lock,
    output logic [PhaseBits-1:0] o_peak_phase,
    output logic [AccBits-1:0]   o_peak_mag,
    output logic [1:0]           o_state
);

    localparam int unsigned CorrBits  = 18;
    localparam int unsigned SumBits   = AccBits + 1;
    localparam int unsigned EpochBits = $clog2(DwellEpochs + 1);
    localparam int unsigned MissBits  = $clog2(MaxMisses + 1);

    localparam logic [EpochBits-1:0] LastEpoch = EpochBits'(DwellEpochs - 1);
    localparam logic [MissBits-1:0]  LastMiss  = MissBits'(MaxMisses - 1);
    localparam logic [PhaseBits-1:0] LastPhase = PhaseBits'(CodeLength - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DWELL  = 2'd2,
        S_TRACK  = 2'd3
    } state_e;

    state_e                r_state,      w_state_nxt;
    logic [PhaseBits-1:0]  r_code_phase, w_code_phase_nxt;
    logic [PhaseBits-1:0]  r_peak_phase, w_peak_phase_nxt;
    logic [AccBits-1:0]    r_peak_mag,   w_peak_mag_nxt;
    logic [AccBits-1:0]    r_acc,        w_acc_nxt;
    logic [EpochBits-1:0]  r_epoch_cnt,  w_epoch_cnt_nxt;
    logic [MissBits-1:0]   r_miss_cnt,   w_miss_cnt_nxt;
    logic                  r_locked,     w_locked_nxt;
    logic                  r_slip,       w_slip_nxt;
    logic                  r_fail,       w_fail_nxt;
    logic                  r_loss,       w_loss_nxt;

    logic [CorrBits-1:0]   w_mag;
    logic [SumBits-1:0]    w_sum;
    logic [AccBits-1:0]    w_final;
    logic                  w_hit;
    logic [PhaseBits-1:0]  w_phase_inc;

    // |corr|; the most negative code has no positive twin, so clamp it
    always_comb begin
        w_mag = 18'(i_corr_in);
        if (i_corr_in[17]) begin
            w_mag = (i_corr_in == 18'sh20000) ? 18'h1FFFF : 18'(-i_corr_in);
        end
    end

    // Saturating accumulate; one spare bit catches the carry
    always_comb begin
        w_sum   = {1'b0, r_acc} + SumBits'(w_mag);
        w_final = w_sum[AccBits] ? '1 : w_sum[AccBits-1:0];
        w_hit   = (w_final >= i_threshold);
    end

    assign w_phase_inc = (r_code_phase == LastPhase) ? '0 : r_code_phase + 1'b1;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decisions; pulses default low every clock
    always_comb begin
        w_state_nxt      = r_state;
        w_code_phase_nxt = r_code_phase;
        w_peak_phase_nxt = r_peak_phase;
        w_peak_mag_nxt   = r_peak_mag;
        w_acc_nxt        = r_acc;
        w_epoch_cnt_nxt  = r_epoch_cnt;
        w_miss_cnt_nxt   = r_miss_cnt;
        w_locked_nxt     = r_locked;
        w_slip_nxt       = 1'b0;
        w_fail_nxt       = 1'b0;
        w_loss_nxt       = 1'b0;

        if (i_clk_en) begin
            if (i_abort) begin
                w_state_nxt     = S_IDLE;
                w_locked_nxt    = 1'b0;
                w_acc_nxt       = '0;
                w_epoch_cnt_nxt = '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            w_state_nxt      = S_SETTLE;
                            w_code_phase_nxt = '0;
                            w_peak_mag_nxt   = '0;
                            w_peak_phase_nxt = '0;
                            w_acc_nxt        = '0;
                            w_epoch_cnt_nxt  = '0;
                            w_miss_cnt_nxt   = '0;
                        end
                    end
                    // First epoch after a phase change is stale pipeline data
                    S_SETTLE: begin
                        if (i_epoch) begin
                            w_state_nxt     = S_DWELL;
                            w_acc_nxt       = '0;
                            w_epoch_cnt_nxt = '0;
                        end
                    end
                    S_DWELL, S_TRACK: begin
                        if (i_epoch) begin
                            if (r_epoch_cnt == LastEpoch) begin
                                w_acc_nxt       = '0;
                                w_epoch_cnt_nxt = '0;
                                if (r_state == S_DWELL) begin
                                    // Strict compare keeps the earliest phase on ties
                                    if (w_final > r_peak_mag) begin
                                        w_peak_mag_nxt   = w_final;
                                        w_peak_phase_nxt = r_code_phase;
                                    end
                                    if (w_hit) begin
                                        w_state_nxt    = S_TRACK;
                                        w_locked_nxt   = 1'b1;
                                        w_miss_cnt_nxt = '0;
                                    end else if (r_code_phase == LastPhase) begin
                                        w_state_nxt      = S_IDLE;
                                        w_fail_nxt       = 1'b1;
                                        w_code_phase_nxt = '0;
                                    end else begin
                                        w_state_nxt      = S_SETTLE;
                                        w_slip_nxt       = 1'b1;
                                        w_code_phase_nxt = w_phase_inc;
                                    end
                                end else begin
                                    if (w_hit) begin
                                        w_miss_cnt_nxt = '0;
                                    end else if (r_miss_cnt == LastMiss) begin
                                        // Lost: resume search one chip further on
                                        w_state_nxt      = S_SETTLE;
                                        w_loss_nxt       = 1'b1;
                                        w_locked_nxt     = 1'b0;
                                        w_slip_nxt       = 1'b1;
                                        w_code_phase_nxt = w_phase_inc;
                                        w_peak_mag_nxt   = '0;
                                        w_miss_cnt_nxt   = '0;
                                    end else begin
                                        w_miss_cnt_nxt = r_miss_cnt + 1'b1;
                                    end
                                end
                            end else begin
                                w_acc_nxt       = w_final;
                                w_epoch_cnt_nxt = r_epoch_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_code_phase <= '0;
            r_peak_phase <= '0;
            r_peak_mag   <= '0;
            r_acc        <= '0;
            r_epoch_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_locked     <= 1'b0;
            r_slip       <= 1'b0;
            r_fail       <= 1'b0;
            r_loss       <= 1'b0;
        end else begin
            r_code_phase <= w_code_phase_nxt;
            r_peak_phase <= w_peak_phase_nxt;
            r_peak_mag   <= w_peak_mag_nxt;
            r_acc        <= w_acc_nxt;
            r_epoch_cnt  <= w_epoch_cnt_nxt;
            r_miss_cnt   <= w_miss_cnt_nxt;
            r_locked     <= w_locked_nxt;
            r_slip       <= w_slip_nxt;
            r_fail       <= w_fail_nxt;
            r_loss       <= w_loss_nxt;
        end
    end

    assign o_slip         = r_slip;
    assign o_code_phase   = r_code_phase;
    assign o_locked       = r_locked;
    assign o_search_fail  = r_fail;
    assign o_loss_of_lock = r_loss;
    assign o_peak_phase   = r_peak_phase;
    assign o_peak_mag     = r_peak_mag;
    assign o_state        = 2'(r_state);

endmodule

// File: tb/tb_despread_acq_ctrl.sv
// Bench for despread_acq_ctrl: directed scenarios with literal expectations
// plus randomized searches, all checked each cycle against a dwell-level model.
module tb_despread_acq_ctrl;

    localparam int unsigned CL  = 16;
    localparam int unsigned PB  = 4;
    localparam int unsigned DE  = 8;
    localparam int unsigned AB  = 18;
    localparam int unsigned MM  = 3;
    localparam longint      ACC_MAX = (longint'(1) << AB) - 1;

    logic                 clk;
    logic                 i_reset, i_clk_en, i_start, i_abort, i_epoch;
    logic signed [17:0]   i_corr_in;
    logic [AB-1:0]        i_threshold;
    logic                 o_slip, o_locked, o_search_fail, o_loss_of_lock;
    logic [PB-1:0]        o_code_phase, o_peak_phase;
    logic [AB-1:0]        o_peak_mag;
    logic [1:0]           o_state;

    despread_acq_ctrl #(
        .CodeLength(CL), .PhaseBits(PB), .DwellEpochs(DE), .AccBits(AB), .MaxMisses(MM)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_start(i_start),
        .i_abort(i_abort), .i_epoch(i_epoch), .i_corr_in(i_corr_in),
        .i_threshold(i_threshold), .o_slip(o_slip), .o_code_phase(o_code_phase),
        .o_locked(o_locked), .o_search_fail(o_search_fail),
        .o_loss_of_lock(o_loss_of_lock), .o_peak_phase(o_peak_phase),
        .o_peak_mag(o_peak_mag), .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Stimulus shaping
    int sig_phase = 0, sig_val = 0, bg_val = 0, noise = 0;
    int cen_mode = 0;   // 0 always on, 1 random, 2 always off
    bit ep_rand = 1'b0;

    // Model: state names as plain ints, dwell kept as a list of magnitudes
    int     m_state = 0, m_phase = 0, m_pphase = 0, m_miss = 0;
    int     m_locked = 0, m_slip = 0, m_fail = 0, m_loss = 0;
    longint m_peak = 0, m_sum = 0;
    int     dq[$];

    int n_slip = 0, n_fail = 0, n_loss = 0;

    function automatic int mag_of(input logic signed [17:0] c);
        int v;
        v = int'(c);
        if (v < 0) v = -v;
        if (v > 131071) v = 131071;
        return v;
    endfunction

    always @(posedge clk) begin
        m_slip = 0;
        m_fail = 0;
        m_loss = 0;
        if (i_reset) begin
            m_state = 0; m_phase = 0; m_pphase = 0; m_peak = 0;
            m_miss = 0; m_locked = 0;
            dq.delete();
        end else if (i_clk_en) begin
            if (i_abort) begin
                m_state = 0; m_locked = 0;
                dq.delete();
            end else if (m_state == 0) begin
                if (i_start) begin
                    m_phase = 0; m_peak = 0; m_pphase = 0; m_miss = 0;
                    dq.delete();
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (i_epoch) begin
                    dq.delete();
                    m_state = 2;
                end
            end else if (i_epoch) begin
                dq.push_back(mag_of(i_corr_in));
                if (dq.size() == DE) begin
                    m_sum = 0;
                    foreach (dq[k]) m_sum += dq[k];
                    dq.delete();
                    if (m_sum > ACC_MAX) m_sum = ACC_MAX;
                    if (m_state == 2) begin
                        if (m_sum > m_peak) begin m_peak = m_sum; m_pphase = m_phase; end
                        if (m_sum >= longint'(i_threshold)) begin
                            m_state = 3; m_locked = 1; m_miss = 0;
                        end else if (m_phase == CL - 1) begin
                            m_state = 0; m_fail = 1; m_phase = 0;
                        end else begin
                            m_slip = 1; m_phase = m_phase + 1; m_state = 1;
                        end
                    end else begin
                        if (m_sum >= longint'(i_threshold)) begin
                            m_miss = 0;
                        end else begin
                            m_miss = m_miss + 1;
                            if (m_miss == MM) begin
                                m_loss = 1; m_locked = 0; m_slip = 1;
                                m_phase = (m_phase + 1) % CL;
                                m_peak = 0; m_miss = 0; m_state = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [31:0] act, exp;
        if (o_slip) n_slip++;
        if (o_search_fail) n_fail++;
        if (o_loss_of_lock) n_loss++;
        if (chk_en) begin
            act = {o_slip, o_code_phase, o_locked, o_search_fail, o_loss_of_lock,
                   o_peak_phase, o_peak_mag, o_state};
            exp = {1'(m_slip), 4'(m_phase), 1'(m_locked), 1'(m_fail), 1'(m_loss),
                   4'(m_pphase), 18'(m_peak), 2'(m_state)};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_compare t=%0t dut={slip,ph,lk,sf,lol,pph,pmag,st}=%h expected=%h",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        int c;
        i_clk_en = (cen_mode == 2) ? 1'b0 :
                   (cen_mode == 1) ? ($urandom_range(0, 9) != 0) : 1'b1;
        i_epoch  = ep_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        c = (m_phase == sig_phase) ? sig_val : bg_val;
        if (noise > 0) c = c + int'($urandom_range(0, 2 * noise)) - noise;
        if (c > 131071) c = 131071;
        if (c < -131072) c = -131072;
        i_corr_in = 18'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic start_search();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_until_locked(input int maxc);
        int n;
        n = 0;
        while (!o_locked && n < maxc) begin tick(); n++; end
        tick();
    endtask

    task automatic set_sig(input int ph, input int sv, input int bg);
        sig_phase = ph; sig_val = sv; bg_val = bg; noise = 0;
    endtask

    int n;
    int amp;

    initial begin
        i_reset = 1'b1; i_clk_en = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_epoch = 1'b0; i_corr_in = '0; i_threshold = '0;
        tick();
        chk_en = 1'b1;
        do_reset();
        chk("reset_outputs", {o_slip, o_code_phase, o_locked, o_search_fail,
            o_loss_of_lock, o_peak_phase, o_peak_mag, o_state}, 64'd0);

        // Zero-offset lock with a 10-clock clkEn gap mid-dwell
        i_threshold = 18'd800; set_sig(0, 100, 100); n_slip = 0;
        start_search();
        tick();                          // settle epoch discarded
        repeat (4) tick();
        cen_mode = 2; repeat (10) tick(); cen_mode = 0;
        chk("gap_state", o_state, 64'd2);
        chk("gap_locked", o_locked, 64'd0);
        repeat (3) tick();
        chk("pre_lock", o_locked, 64'd0);
        tick();
        chk("zero_lock", o_locked, 64'd1);
        chk("zero_phase", o_code_phase, 64'd0);
        chk("zero_peak", o_peak_mag, 64'd800);
        chk("zero_slips", n_slip, 64'd0);
        // Reset mid-TRACK
        tick(); tick();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        chk("reset_in_track", {o_slip, o_code_phase, o_locked, o_search_fail,
            o_loss_of_lock, o_peak_phase, o_peak_mag, o_state}, 64'd0);

        // Offset 5
        do_reset();
        i_threshold = 18'd900; set_sig(5, -120, 3); n_slip = 0;
        start_search();
        run_until_locked(2000);
        chk("off5_slips", n_slip, 64'd5);
        chk("off5_locked", o_locked, 64'd1);
        chk("off5_phase", o_code_phase, 64'd5);
        chk("off5_pphase", o_peak_phase, 64'd5);
        chk("off5_peak", o_peak_mag, 64'd960);

        // No signal: full search fails, then held start restarts
        do_reset();
        i_threshold = 18'd1000; set_sig(0, 2, 2); n_slip = 0; n_fail = 0;
        start_search();
        n = 0;
        while (!o_search_fail && n < 3000) begin tick(); n++; end
        chk("nosig_state", o_state, 64'd0);
        chk("nosig_phase", o_code_phase, 64'd0);
        chk("nosig_peak", o_peak_mag, 64'd16);
        i_start = 1'b1; tick(); i_start = 1'b0;
        chk("nosig_slips", n_slip, 64'd15);
        chk("nosig_fails", n_fail, 64'd1);
        chk("restart_state", o_state, 64'd1);

        // Loss of lock at phase 3
        do_reset();
        i_threshold = 18'd900; set_sig(3, 200, 0); n_loss = 0;
        start_search();
        run_until_locked(2000);
        chk("lol_lock_phase", o_code_phase, 64'd3);
        sig_val = 0;
        n = 0;
        while (!o_loss_of_lock && n < 200) begin tick(); n++; end
        chk("lol_ticks", n, 64'd23);
        chk("lol_slip", o_slip, 64'd1);
        chk("lol_phase", o_code_phase, 64'd4);
        chk("lol_state", o_state, 64'd1);
        chk("lol_locked", o_locked, 64'd0);
        chk("lol_peak", o_peak_mag, 64'd0);

        // Saturation with the most negative input
        do_reset();
        i_threshold = 18'(ACC_MAX); set_sig(0, -131072, -131072);
        start_search();
        run_until_locked(100);
        chk("sat_locked", o_locked, 64'd1);
        chk("sat_peak", o_peak_mag, 64'(ACC_MAX));

        // Zero threshold locks on the first dwell
        do_reset();
        i_threshold = 18'd0; set_sig(0, 0, 0); n_slip = 0;
        start_search();
        run_until_locked(100);
        chk("thr0_locked", o_locked, 64'd1);
        chk("thr0_phase", o_code_phase, 64'd0);
        chk("thr0_slips", n_slip, 64'd0);

        // Abort mid-DWELL, then abort on the slip cycle
        do_reset();
        i_threshold = 18'd1000; set_sig(0, 2, 2);
        start_search();
        repeat (4) tick();
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        chk("abort_state", o_state, 64'd0);
        chk("abort_slip", o_slip, 64'd0);
        start_search();
        n = 0;
        while (!o_slip && n < 100) begin tick(); n++; end
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        chk("abort_slip_state", o_state, 64'd0);
        chk("abort_slip_pulse", o_slip, 64'd0);
        chk("abort_slip_phase", o_code_phase, 64'd1);

        // Randomized searches, some losing the signal midway
        for (int it = 0; it < 8; it++) begin
            cen_mode = 0; ep_rand = 1'b0;
            do_reset();
            amp = int'($urandom_range(150, 3000));
            set_sig(int'($urandom_range(0, CL - 1)),
                    ($urandom_range(0, 1) != 0) ? amp : -amp,
                    int'($urandom_range(0, 5)));
            noise = int'($urandom_range(0, 3));
            i_threshold = 18'($urandom_range(0, 9 * amp));
            cen_mode = 1; ep_rand = 1'b1;
            for (int k = 0; k < 1500; k++) begin
                if (k == 800 && (it % 2) == 1) sig_val = 0;
                i_start = ($urandom_range(0, 3) == 0);
                i_abort = ($urandom_range(0, 199) == 0);
                tick();
            end
            i_start = 1'b0; i_abort = 1'b0;
        end
        cen_mode = 0; ep_rand = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/despread_acq_ctrl.md
Name: despread_acq_ctrl

Overview:
Code-phase acquisition and lock controller for the despread correlator.
- Steps the local code phase one chip at a time by pulsing `slip` to the code generator.
- Per hypothesis, integrates correlator magnitude over a fixed number of code epochs and compares the result against a programmable threshold.
- Declares lock on a hit. In track, declares loss after consecutive misses and re-enters search.
- Sits between the code generator, the correlator output and the demod status registers.

Parameters:
CodeLength, 16, chips per code period; number of phase hypotheses.
PhaseBits, 4, width of phase index; 2**PhaseBits >= CodeLength.
DwellEpochs, 8, epochs integrated per hypothesis (>=1).
AccBits, 24, accumulator width.
MaxMisses, 3, consecutive failed dwells in TRACK before loss (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clkEn  in  1  chip-rate enable; all state advances only when high
start  in  1  level; begin search from IDLE
abort  in  1  pulse; return to IDLE from any state
epoch  in  1  high (with clkEn) on the chip where corrIn holds the full-period correlation
corrIn  in  18  signed correlator output
threshold  in  AccBits  unsigned detection threshold
slip  out  1  one-clkEn-cycle pulse; code generator holds one chip (phase += 1)
codePhase  out  PhaseBits  current hypothesis index
locked  out  1  high in TRACK
searchFail  out  1  one-clkEn-cycle pulse when all phases fail
lossOfLock  out  1  one-clkEn-cycle pulse on TRACK→SEARCH
peakPhase  out  PhaseBits  phase of largest dwell seen in current search
peakMag  out  AccBits  largest dwell accumulation in current search
state  out  2  0 IDLE, 1 SETTLE, 2 DWELL, 3 TRACK

Behaviour:
Reset:
- state=IDLE; all outputs 0; acc=0; counters 0.

Gating:
- reset has priority over everything.
- abort has priority over every other event and takes effect on the next clkEn edge.
- With clkEn low, all registers hold and pulse outputs hold 0.

Magnitude and accumulation:
- mag = |corrIn|. -131072 maps to 131071.
- Zero-extend mag to AccBits; acc += mag, saturating at 2**AccBits-1.

IDLE:
- start=1 → clear codePhase, peakMag, peakPhase, acc, missCnt → SETTLE.

SETTLE:
- Discard the first epoch (correlator pipeline refill), then → DWELL with acc=0, epochCnt=0.

DWELL:
- Each epoch: accumulate; epochCnt++.
- On the epoch where epochCnt reaches DwellEpochs:
  - Compute final = acc + mag.
  - If final > peakMag, update peakMag/peakPhase (strict >, so the earliest phase wins ties).
  - If final >= threshold → TRACK, locked=1, missCnt=0.
  - Else if codePhase==CodeLength-1 → IDLE, searchFail=1, codePhase=0.
  - Else slip=1, codePhase++, → SETTLE.
- Latency: decision registered on the epoch edge; slip asserts the same cycle.

TRACK:
- Same dwell integration, no slips, codePhase held.
- final >= threshold → missCnt=0.
- Else missCnt++. When missCnt reaches MaxMisses:
  - lossOfLock=1, locked=0.
  - Restart search at the next phase: slip=1, codePhase++ with wrap to 0 after CodeLength-1.
  - Clear peakMag → SETTLE.

Boundary conditions:
- start while not IDLE: ignored.
- start held high in IDLE after searchFail: a new search starts on the next clkEn.
- epoch with state IDLE: ignored.
- abort during slip cycle: slip still deasserts next cycle; codePhase holds its current value.
- threshold=0: lock on first dwell at phase 0.
- threshold > max possible: searchFail after exactly CodeLength dwells and CodeLength-1 slips.

Test Plan:
1. Zero-offset lock: corrIn=+100 at phase 0, threshold=800, DwellEpochs=8 → no slip; locked=1 on 8th post-settle epoch; codePhase=0.
2. Offset 5: corrIn=-120 only when codePhase==5 (else 3), threshold=900 → exactly 5 slip pulses, then locked=1, codePhase=5, peakPhase=5, peakMag=960.
3. No signal: corrIn=2 always, threshold=1000 → 15 slips, searchFail pulse after 16 dwells, state=IDLE, peakMag=16.
4. Loss of lock: lock at phase 3, then corrIn=0 → lossOfLock pulse after 3 dwells with slip; codePhase=4; state=SETTLE.
5. Saturation: corrIn=-131072 with AccBits=18 → mag 131071; acc saturates at 262143, no wrap.
6. Reset/abort/clkEn: abort mid-DWELL → IDLE next clkEn edge, slip=0; synchronous reset mid-TRACK → all outputs 0 on the next clk edge; clkEn low for 10 clocks → no counter change.
